// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic definitions for q = 2^28 - 2^16 + 1.
// This package holds the modulus, the residue and twiddle-table types, and the
// modular helper functions used by the butterfly and the multiplier.
package ntt_pkg;

    localparam logic [27:0] Q = 28'hFFF0001;

    typedef logic [27:0] residue_t;
    typedef residue_t twiddle_tbl_t [64];

    typedef enum logic {
        SEQ_DELAY = 1'b0,
        SEQ_RUN   = 1'b1
    } seq_state_t;

    // (a + b) mod q for a, b < q
    function automatic residue_t mod_add(input residue_t a, input residue_t b);
        logic [28:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) begin
            s = s - {1'b0, Q};
        end
        return residue_t'(s);
    endfunction

    // (a - b) mod q for a, b < q; the 28-bit wrap is exact because the result is < q
    function automatic residue_t mod_sub(input residue_t a, input residue_t b);
        residue_t d;
        if (a < b) begin
            d = a - b + Q;
        end else begin
            d = a - b;
        end
        return d;
    endfunction

    // s * 2^-1 mod q: odd values borrow one q so the shift is exact
    function automatic residue_t mod_halve(input residue_t s);
        logic [28:0] t;
        if (s[0]) begin
            t = {1'b0, s} + {1'b0, Q};
        end else begin
            t = {1'b0, s};
        end
        return residue_t'(t >> 1);
    endfunction

    // a * b mod q using 2^28 == 2^16 - 1 (mod q); three folds bring the
    // 56-bit product under 2q, then one conditional subtract finishes it
    function automatic residue_t mod_mul(input residue_t a, input residue_t b);
        logic [55:0] p;
        logic [44:0] t;
        logic [33:0] u;
        logic [28:0] v;
        p = 56'(a) * 56'(b);
        t = 45'({p[55:28], 16'h0000}) - 45'(p[55:28]) + 45'(p[27:0]);
        u = 34'({t[44:28], 16'h0000}) - 34'(t[44:28]) + 34'(t[27:0]);
        v = 29'({u[33:28], 16'h0000}) - 29'(u[33:28]) + 29'(u[27:0]);
        if (v >= {1'b0, Q}) begin
            v = v - {1'b0, Q};
        end
        return residue_t'(v);
    endfunction

endpackage

// File: rtl/modular_mult.sv
// Pipelined modular multiplier, p = a * b mod q, result LAT cycles after the operands.
// The reduction is computed in front of the pipe; the registers behind it give
// retiming room to spread the product and folds across the stages.
module modular_mult
    import ntt_pkg::*;
#(
    parameter int LAT = 5
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  residue_t a_i,
    input  residue_t b_i,
    output residue_t p_o
);

    residue_t pipe_q [LAT];

    // product register followed by a plain delay line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= mod_mul(a_i, b_i);
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign p_o = pipe_q[LAT-1];

endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande radix-2 butterfly for the INTT stage columns.
// x_out = (x + y) mod q, optionally halved; y_out = ((x - y) mod q) * w mod q,
// with w stepped through FACTORS by a start-delayed twiddle sequencer.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// SEQ_DELAY | waiting for START accepted beats; every beat uses FACTORS[0]
// SEQ_RUN   | index advances once per accepted beat, wrapping 63 -> 0
module gs_butterfly
    import ntt_pkg::*;
#(
    parameter logic [7:0]   START    = 8'd6,
    parameter twiddle_tbl_t FACTORS  = '{default: 28'd1},
    parameter bit           HALVE    = 1'b0,
    parameter int           MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [27:0] x_in,
    input  logic [27:0] y_in,
    output logic        out_valid,
    output logic [27:0] x_out,
    output logic [27:0] y_out
);

    localparam seq_state_t SEQ_RST = (START == 8'd0) ? SEQ_RUN : SEQ_DELAY;

    seq_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;

    residue_t    s1_q, d1_q, w1_q;
    residue_t    s_dly_q [MULT_LAT];
    logic [MULT_LAT:0] vld_q;
    residue_t    prod;
    residue_t    x_pre;

    residue_t    x_out_q, y_out_q;
    logic        out_valid_q;

    // sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEQ_RST;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // sequencer next state; the beat that completes the delay also steps the
    // index so the beat after it already uses FACTORS[1]
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (in_valid) begin
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            case (state_q)
                SEQ_DELAY: begin
                    if (cnt_q == START - 8'd1) begin
                        state_d = SEQ_RUN;
                        idx_d   = 6'd1;
                    end
                end
                SEQ_RUN: begin
                    idx_d = idx_q + 6'd1;
                end
                default: begin
                    state_d = SEQ_RST;
                end
            endcase
        end
    end

    // S1 sum/difference with twiddle capture, sum delay line and valid pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            d1_q <= '0;
            w1_q <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                s_dly_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            s1_q       <= mod_add(x_in, y_in);
            d1_q       <= mod_sub(x_in, y_in);
            w1_q       <= FACTORS[idx_q];
            s_dly_q[0] <= s1_q;
            for (int i = 1; i < MULT_LAT; i++) begin
                s_dly_q[i] <= s_dly_q[i-1];
            end
            vld_q <= {vld_q[MULT_LAT-1:0], in_valid};
        end
    end

    modular_mult #(
        .LAT (MULT_LAT)
    ) u_mult (
        .clk_i (clk),
        .rst_i (rst),
        .a_i   (d1_q),
        .b_i   (w1_q),
        .p_o   (prod)
    );

    assign x_pre = HALVE ? mod_halve(s_dly_q[MULT_LAT-1]) : s_dly_q[MULT_LAT-1];

    // output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_out_q     <= x_pre;
            y_out_q     <= prod;
            out_valid_q <= vld_q[MULT_LAT];
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gs_butterfly.sv
// Scoreboard bench for gs_butterfly: dut_a (START=6, HALVE=0) and dut_h
// (START=0, HALVE=1), both with FACTORS[i] = i+1.
module tb_gs_butterfly;
    import ntt_pkg::*;

    typedef struct {
        int       t;
        residue_t x;
        residue_t y;
    } exp_t;

    function automatic twiddle_tbl_t ramp_tbl();
        twiddle_tbl_t t;
        for (int i = 0; i < 64; i++) begin
            t[i] = residue_t'(i + 1);
        end
        return t;
    endfunction

    localparam twiddle_tbl_t RAMP = ramp_tbl();

    // twiddle for accepted beat k (1-based) of dut_a: beats 1..6 use index 0,
    // beat 7 uses index 1, and the index wraps every 64 beats after that
    function automatic int w_a(input int k);
        if (k <= 6) return 1;
        return ((k - 6) % 64) + 1;
    endfunction

    logic     clk = 1'b0;
    logic     rst_a, rst_h;
    logic     va, vh;
    residue_t xa, ya, xh, yh;
    logic     ova, ovh;
    residue_t xoa, yoa, xoh, yoh;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qh[$];
    exp_t ea, eh;

    gs_butterfly #(
        .START    (8'd6),
        .FACTORS  (RAMP),
        .HALVE    (1'b0),
        .MULT_LAT (5)
    ) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .in_valid  (va),
        .x_in      (xa),
        .y_in      (ya),
        .out_valid (ova),
        .x_out     (xoa),
        .y_out     (yoa)
    );

    gs_butterfly #(
        .START    (8'd0),
        .FACTORS  (RAMP),
        .HALVE    (1'b1),
        .MULT_LAT (5)
    ) dut_h (
        .clk       (clk),
        .rst       (rst_h),
        .in_valid  (vh),
        .x_in      (xh),
        .y_in      (yh),
        .out_valid (ovh),
        .x_out     (xoh),
        .y_out     (yoh)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic beat_a(input logic v, input residue_t x, input residue_t y,
                          input residue_t ex, input residue_t ey);
        @(posedge clk);
        #1;
        va = v;
        xa = x;
        ya = y;
        if (v) qa.push_back('{cyc + 7, ex, ey});
    endtask

    task automatic beat_h(input logic v, input residue_t x, input residue_t y,
                          input residue_t ex, input residue_t ey);
        @(posedge clk);
        #1;
        vh = v;
        xh = x;
        yh = y;
        if (v) qh.push_back('{cyc + 7, ex, ey});
    endtask

    // monitor: compare every presented beat against the head of its queue
    always @(negedge clk) begin
        if (!rst_a) begin
            if (ova) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_spurious: out_valid at cycle %0d, expected none", cyc);
                end else begin
                    ea = qa.pop_front();
                    n_cmp++;
                    if (ea.t != cyc || xoa != ea.x || yoa != ea.y) begin
                        n_bad++;
                        $display("FAIL a_beat: cycle %0d x_out %0d y_out %0d, expected cycle %0d x_out %0d y_out %0d",
                                 cyc, xoa, yoa, ea.t, ea.x, ea.y);
                    end
                end
            end else if (qa.size() > 0 && qa[0].t <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_missing: no out_valid at cycle %0d, expected beat due at %0d", cyc, qa[0].t);
                void'(qa.pop_front());
            end
        end
        if (!rst_h) begin
            if (ovh) begin
                if (qh.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL h_spurious: out_valid at cycle %0d, expected none", cyc);
                end else begin
                    eh = qh.pop_front();
                    n_cmp++;
                    if (eh.t != cyc || xoh != eh.x || yoh != eh.y) begin
                        n_bad++;
                        $display("FAIL h_beat: cycle %0d x_out %0d y_out %0d, expected cycle %0d x_out %0d y_out %0d",
                                 cyc, xoh, yoh, eh.t, eh.x, eh.y);
                    end
                end
            end else if (qh.size() > 0 && qh[0].t <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL h_missing: no out_valid at cycle %0d, expected beat due at %0d", cyc, qh[0].t);
                void'(qh.pop_front());
            end
        end
    end

    initial begin
        int pulses;
        rst_a = 1'b1;
        rst_h = 1'b1;
        va = 1'b0; xa = '0; ya = '0;
        vh = 1'b0; xh = '0; yh = '0;

        #2;
        chk("a_rst_valid", int'(ova), 0);
        chk("a_rst_x", int'(xoa), 0);
        chk("a_rst_y", int'(yoa), 0);
        chk("h_rst_valid", int'(ovh), 0);
        chk("h_rst_x", int'(xoh), 0);
        chk("h_rst_y", int'(yoh), 0);

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_h = 1'b0;

        // dut_a: sum/difference, wrap cases, then the twiddle ramp with bubbles
        beat_a(1'b1, 28'd5, 28'd3, 28'd8, 28'd2);
        beat_a(1'b1, 28'd3, 28'd5, 28'd8, 28'd268369919);
        beat_a(1'b1, 28'd268369920, 28'd268369920, 28'd268369919, 28'd0);
        for (int k = 4; k <= 70; k++) begin
            if (k == 21) begin
                repeat (2) beat_a(1'b0, 28'd77, 28'd11, 28'd0, 28'd0);
            end
            if (k == 41) begin
                repeat (3) beat_a(1'b0, 28'd99, 28'd1, 28'd0, 28'd0);
            end
            beat_a(1'b1, residue_t'(k), 28'd0, residue_t'(k), residue_t'(k * w_a(k)));
        end
        beat_a(1'b0, 28'd0, 28'd0, 28'd0, 28'd0);
        repeat (10) @(posedge clk);

        // dut_h: halving and START=0 twiddle order, one bubble inside
        beat_h(1'b1, 28'd1, 28'd2, 28'd134184962, 28'd268369920);
        beat_h(1'b1, 28'd2, 28'd2, 28'd2, 28'd0);
        beat_h(1'b1, 28'd0, 28'd0, 28'd0, 28'd0);
        beat_h(1'b0, 28'd9, 28'd4, 28'd0, 28'd0);
        beat_h(1'b1, 28'd5, 28'd1, 28'd3, 28'd16);
        beat_h(1'b1, 28'd268369920, 28'd268369920, 28'd268369920, 28'd0);
        beat_h(1'b1, 28'd7, 28'd3, 28'd5, 28'd24);
        beat_h(1'b1, 28'd268369920, 28'd0, 28'd134184960, 28'd268369914);
        beat_h(1'b1, 28'd0, 28'd1, 28'd134184961, 28'd268369913);
        beat_h(1'b1, 28'd268369920, 28'd1, 28'd0, 28'd268369903);
        beat_h(1'b0, 28'd0, 28'd0, 28'd0, 28'd0);
        repeat (10) @(posedge clk);

        // dut_a: continue the ramp (beats 71..80), then reset with beats in flight
        for (int j = 0; j < 10; j++) begin
            beat_a(1'b1, 28'd3, 28'd1, 28'd4, residue_t'(2 * (2 + j)));
        end
        beat_a(1'b0, 28'd0, 28'd0, 28'd0, 28'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_a = 1'b1;
        qa.delete();
        #1;
        chk("a_midrst_valid", int'(ova), 0);
        chk("a_midrst_x", int'(xoa), 0);
        chk("a_midrst_y", int'(yoa), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ova) pulses++;
        end
        chk("a_post_rst_pulses", pulses, 0);

        // START count restarts: six beats at w=1, then w=2, w=3
        for (int k = 1; k <= 8; k++) begin
            beat_a(1'b1, 28'd9, 28'd2, 28'd11, residue_t'(7 * w_a(k)));
        end
        beat_a(1'b0, 28'd0, 28'd0, 28'd0, 28'd0);

        for (int i = 0; i < 60 && (qa.size() > 0 || qh.size() > 0); i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain_pending", qa.size() + qh.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
